// File: rtl/reg_writeback.sv
// ---------------------------------------------------------------------------
// reg_writeback
//
// Writeback queue between the execute/load stages and the register file.
// Results ({rd, data}) are queued in a small FIFO and drained one per cycle
// into a registered write port (wr_en / wr_addr / wr_data). While a result is
// queued or sitting in the write port, the read-port decoders can look it up
// so younger instructions either forward the value or stall on it.
//
// Build option:
//   WB_FORWARD_EN  defined   -> lk_dataN carries the newest pending value
//                                for lk_addrN.
//                  undefined -> lk_hitN still flags pending writes and acts
//                                as a stall request; lk_dataN is tied to 0.
//
// Ports:
//   clk, rst_n            clock, async active-low reset
//   in_valid/in_ready     result handshake (in_ready = queue not full)
//   in_rd, in_data        destination register index and value
//   flush                 drop every queued, uncommitted result
//   wb_stall              hold the queue head this cycle
//   wr_en/wr_addr/wr_data registered register-file write port
//   lk_addrN/lk_hitN/lk_dataN   pending-write lookup, N = 1, 2
//   count                 number of queued entries (0..DEPTH)
// ---------------------------------------------------------------------------

// Match one pending-write slot against both lookup addresses. Register 0 is
// hard-wired, so a lookup of x0 never hits.
module wb_slot_match (
  input  logic       vld,
  input  logic [4:0] rd,
  input  logic [4:0] a1,
  input  logic [4:0] a2,
  output logic       hit1,
  output logic       hit2
);
  assign hit1 = vld && (rd == a1) && (a1 != 5'd0);
  assign hit2 = vld && (rd == a2) && (a2 != 5'd0);
endmodule

module reg_writeback #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [4:0]                in_rd,
  input  logic [DATA_WIDTH-1:0]     in_data,
  input  logic                      flush,
  input  logic                      wb_stall,
  output logic                      wr_en,
  output logic [4:0]                wr_addr,
  output logic [DATA_WIDTH-1:0]     wr_data,
  input  logic [4:0]                lk_addr1,
  input  logic [4:0]                lk_addr2,
  output logic                      lk_hit1,
  output logic                      lk_hit2,
  output logic [DATA_WIDTH-1:0]     lk_data1,
  output logic [DATA_WIDTH-1:0]     lk_data2,
  output logic [$clog2(DEPTH):0]    count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef struct packed {
    logic [4:0]            rd;
    logic [DATA_WIDTH-1:0] data;
  } wb_ent_t;

  // Queue storage: written only on push, never reset.
  wb_ent_t mem_q [DEPTH];

  logic [AW-1:0]         wptr_q, wptr_d;
  logic [AW-1:0]         rptr_q, rptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  wr_en_q, wr_en_d;
  logic [4:0]            wr_addr_q, wr_addr_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;

  logic    push, pop;
  wb_ent_t head;

  // Full is judged on the current count only, so a full queue refuses a
  // push even if it pops in the same cycle.
  assign in_ready = (count_q != FULL_CNT);
  assign push     = in_valid && in_ready && !flush;
  assign pop      = (count_q != '0) && !wb_stall && !flush;
  assign head     = mem_q[rptr_q];

  always_comb begin
    wptr_d    = wptr_q;
    rptr_d    = rptr_q;
    count_d   = count_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    if (flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      // Pointers are AW bits wide, so the increment wraps modulo DEPTH.
      if (push) wptr_d = wptr_q + AW'(1);
      if (pop)  rptr_d = rptr_q + AW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
    end
    if (pop) begin
      // x0 results still drain through the port but never write.
      wr_en_d   = (head.rd != 5'd0);
      wr_addr_d = head.rd;
      wr_data_d = head.data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q    <= '0;
      rptr_q    <= '0;
      count_q   <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      count_q   <= count_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= '{rd: in_rd, data: in_data};
  end

  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign count   = count_q;

  // -------------------------------------------------------------------------
  // Pending-write lookup. Slots are ordered by age: slot 0 is the write port
  // (oldest), slot g+1 is the queue entry g places behind the head. A later
  // slot is always younger, so the highest-numbered hit wins.
  // -------------------------------------------------------------------------
  logic [DEPTH:0]        slot_vld;
  logic [DEPTH:0][4:0]   slot_rd;
  logic [DEPTH:0]        hit1_v, hit2_v;
`ifdef WB_FORWARD_EN
  logic [DEPTH:0][DATA_WIDTH-1:0] slot_data;
`endif

  assign slot_vld[0] = wr_en_q;
  assign slot_rd[0]  = wr_addr_q;
`ifdef WB_FORWARD_EN
  assign slot_data[0] = wr_data_q;
`endif

  for (genvar g = 0; g < DEPTH; g++) begin : g_slot
    logic [AW-1:0] idx;
    assign idx           = rptr_q + AW'(g);
    assign slot_vld[g+1] = (CW'(g) < count_q);
    assign slot_rd[g+1]  = mem_q[idx].rd;
`ifdef WB_FORWARD_EN
    assign slot_data[g+1] = mem_q[idx].data;
`endif
  end

  for (genvar s = 0; s <= DEPTH; s++) begin : g_match
    wb_slot_match u_match (
      .vld  (slot_vld[s]),
      .rd   (slot_rd[s]),
      .a1   (lk_addr1),
      .a2   (lk_addr2),
      .hit1 (hit1_v[s]),
      .hit2 (hit2_v[s])
    );
  end

  assign lk_hit1 = |hit1_v;
  assign lk_hit2 = |hit2_v;

`ifdef WB_FORWARD_EN
  always_comb begin
    lk_data1 = '0;
    lk_data2 = '0;
    for (int i = 0; i <= DEPTH; i++) begin
      if (hit1_v[i]) lk_data1 = slot_data[i];
      if (hit2_v[i]) lk_data2 = slot_data[i];
    end
  end
`else
  assign lk_data1 = '0;
  assign lk_data2 = '0;
`endif

endmodule

// File: tb/tb_reg_writeback.sv
// Directed, table-driven bench for reg_writeback (DATA_WIDTH=32, DEPTH=4).
// Each vector drives inputs at the falling edge; expectations describe the
// outputs 1 time unit after the following rising edge.
module tb_reg_writeback;
`ifdef WB_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0, in_ready;
  logic [4:0]  in_rd = '0;
  logic [31:0] in_data = '0;
  logic        flush = 1'b0, wb_stall = 1'b0;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [4:0]  lk_addr1 = '0, lk_addr2 = '0;
  logic        lk_hit1, lk_hit2;
  logic [31:0] lk_data1, lk_data2;
  logic [2:0]  count;

  always #5 clk = ~clk;

  reg_writeback #(.DATA_WIDTH(32), .DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_rd(in_rd), .in_data(in_data), .flush(flush), .wb_stall(wb_stall),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .lk_addr1(lk_addr1), .lk_addr2(lk_addr2), .lk_hit1(lk_hit1),
    .lk_hit2(lk_hit2), .lk_data1(lk_data1), .lk_data2(lk_data2),
    .count(count)
  );

  typedef struct {
    logic        v;
    logic [4:0]  rd;
    logic [31:0] d;
    logic        st, fl;
    logic [4:0]  a1, a2;
    logic        e_en;
    logic [4:0]  e_addr;
    logic [31:0] e_data;
    logic [2:0]  e_cnt;
    logic        e_rdy;
    logic        e_h1;
    logic [31:0] e_d1;
    logic        e_h2;
    logic [31:0] e_d2;
  } vec_t;

  vec_t vq[$];
  int   n_vec = 0;
  int   n_bad = 0;

  function automatic vec_t mk(logic v, logic [4:0] rd, logic [31:0] d,
                              logic st, logic fl, logic [4:0] a1, logic [4:0] a2,
                              logic e_en, logic [4:0] e_addr, logic [31:0] e_data,
                              logic [2:0] e_cnt, logic e_rdy,
                              logic e_h1, logic [31:0] e_d1,
                              logic e_h2, logic [31:0] e_d2);
    vec_t r;
    r.v = v; r.rd = rd; r.d = d; r.st = st; r.fl = fl; r.a1 = a1; r.a2 = a2;
    r.e_en = e_en; r.e_addr = e_addr; r.e_data = e_data; r.e_cnt = e_cnt;
    r.e_rdy = e_rdy; r.e_h1 = e_h1; r.e_d1 = e_d1; r.e_h2 = e_h2; r.e_d2 = e_d2;
    return r;
  endfunction

  task automatic chk(input string nm, input int idx,
                     input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0d: got 0x%0h want 0x%0h", nm, idx, act, exp);
    end
  endtask

  task automatic chk_all(input int idx, input vec_t e);
    chk("wr_en",    idx, 32'(wr_en),    32'(e.e_en));
    chk("wr_addr",  idx, 32'(wr_addr),  32'(e.e_addr));
    chk("wr_data",  idx, wr_data,       e.e_data);
    chk("count",    idx, 32'(count),    32'(e.e_cnt));
    chk("in_ready", idx, 32'(in_ready), 32'(e.e_rdy));
    chk("lk_hit1",  idx, 32'(lk_hit1),  32'(e.e_h1));
    chk("lk_hit2",  idx, 32'(lk_hit2),  32'(e.e_h2));
    chk("lk_data1", idx, lk_data1,      FWD ? e.e_d1 : 32'h0);
    chk("lk_data2", idx, lk_data2,      FWD ? e.e_d2 : 32'h0);
  endtask

  task automatic drive(input vec_t x);
    in_valid = x.v; in_rd = x.rd; in_data = x.d;
    wb_stall = x.st; flush = x.fl; lk_addr1 = x.a1; lk_addr2 = x.a2;
  endtask

  localparam logic [31:0] DB = 32'hDEADBEEF;

  initial begin
    vec_t z;
    // Latency: push at edge k commits via the port between k+1 and k+2.
    vq.push_back(mk(1,5,DB,   0,0, 0,5, 0,0,0,     1,1, 0,0, 1,DB));
    vq.push_back(mk(0,0,0,    0,0, 0,5, 1,5,DB,    0,1, 0,0, 1,DB));
    vq.push_back(mk(0,0,0,    0,0, 0,5, 0,5,DB,    0,1, 0,0, 0,0));
    // Stall and fill; 5th push refused; drain in order.
    vq.push_back(mk(1,1,'h11, 1,0, 0,0, 0,5,DB,    1,1, 0,0, 0,0));
    vq.push_back(mk(1,2,'h22, 1,0, 0,0, 0,5,DB,    2,1, 0,0, 0,0));
    vq.push_back(mk(1,3,'h33, 1,0, 0,0, 0,5,DB,    3,1, 0,0, 0,0));
    vq.push_back(mk(1,4,'h44, 1,0, 4,2, 0,5,DB,    4,0, 1,'h44, 1,'h22));
    vq.push_back(mk(1,6,'h66, 1,0, 6,1, 0,5,DB,    4,0, 0,0, 1,'h11));
    vq.push_back(mk(0,0,0,    0,0, 0,0, 1,1,'h11,  3,1, 0,0, 0,0));
    vq.push_back(mk(0,0,0,    0,0, 0,0, 1,2,'h22,  2,1, 0,0, 0,0));
    vq.push_back(mk(0,0,0,    0,0, 0,0, 1,3,'h33,  1,1, 0,0, 0,0));
    vq.push_back(mk(0,0,0,    0,0, 0,0, 1,4,'h44,  0,1, 0,0, 0,0));
    vq.push_back(mk(0,0,0,    0,0, 0,0, 0,4,'h44,  0,1, 0,0, 0,0));
    // Full queue + pop in the same cycle still refuses the push.
    vq.push_back(mk(1,8,'h80, 1,0, 0,0, 0,4,'h44,  1,1, 0,0, 0,0));
    vq.push_back(mk(1,9,'h90, 1,0, 0,0, 0,4,'h44,  2,1, 0,0, 0,0));
    vq.push_back(mk(1,10,'hA0,1,0, 0,0, 0,4,'h44,  3,1, 0,0, 0,0));
    vq.push_back(mk(1,11,'hB0,1,0, 0,0, 0,4,'h44,  4,0, 0,0, 0,0));
    vq.push_back(mk(1,12,'hC0,0,0, 0,0, 1,8,'h80,  3,1, 0,0, 0,0));
    // Push + pop on a non-full queue keeps count.
    vq.push_back(mk(1,12,'hC0,0,0, 0,12,1,9,'h90,  3,1, 0,0, 1,'hC0));
    vq.push_back(mk(0,0,0,    0,0, 0,0, 1,10,'hA0, 2,1, 0,0, 0,0));
    vq.push_back(mk(0,0,0,    0,0, 0,0, 1,11,'hB0, 1,1, 0,0, 0,0));
    vq.push_back(mk(0,0,0,    0,0, 0,0, 1,12,'hC0, 0,1, 0,0, 0,0));
    vq.push_back(mk(0,0,0,    0,0, 0,0, 0,12,'hC0, 0,1, 0,0, 0,0));
    // rd=0: no write pulse, x0 lookup never hits.
    vq.push_back(mk(1,0,1,    0,0, 0,0, 0,12,'hC0, 1,1, 0,0, 0,0));
    vq.push_back(mk(0,0,0,    0,0, 0,0, 0,0,1,     0,1, 0,0, 0,0));
    // Two pending writes to x7: newest wins, including over the port.
    vq.push_back(mk(1,7,'h10, 1,0, 0,7, 0,0,1,     1,1, 0,0, 1,'h10));
    vq.push_back(mk(1,7,'h20, 1,0, 0,7, 0,0,1,     2,1, 0,0, 1,'h20));
    vq.push_back(mk(0,0,0,    1,0, 7,7, 0,0,1,     2,1, 1,'h20, 1,'h20));
    vq.push_back(mk(0,0,0,    0,0, 0,7, 1,7,'h10,  1,1, 0,0, 1,'h20));
    vq.push_back(mk(0,0,0,    0,0, 0,7, 1,7,'h20,  0,1, 0,0, 1,'h20));
    vq.push_back(mk(0,0,0,    0,0, 0,7, 0,7,'h20,  0,1, 0,0, 0,0));
    // Flush with in_valid=1 on a 3-entry queue.
    vq.push_back(mk(1,1,1,    1,0, 0,0, 0,7,'h20,  1,1, 0,0, 0,0));
    vq.push_back(mk(1,2,2,    1,0, 0,0, 0,7,'h20,  2,1, 0,0, 0,0));
    vq.push_back(mk(1,3,3,    1,0, 0,0, 0,7,'h20,  3,1, 0,0, 0,0));
    vq.push_back(mk(1,9,'h99, 0,1, 1,9, 0,7,'h20,  0,1, 0,0, 0,0));
    vq.push_back(mk(0,0,0,    0,0, 0,0, 0,7,'h20,  0,1, 0,0, 0,0));
    vq.push_back(mk(0,0,0,    0,0, 0,0, 0,7,'h20,  0,1, 0,0, 0,0));
    // Flush while the port is writing: that write completes, the rest drops.
    vq.push_back(mk(1,3,'h33, 0,0, 0,0, 0,7,'h20,  1,1, 0,0, 0,0));
    vq.push_back(mk(1,4,'h44, 0,0, 0,0, 1,3,'h33,  1,1, 0,0, 0,0));
    vq.push_back(mk(0,0,0,    0,1, 4,0, 0,3,'h33,  0,1, 0,0, 0,0));
    vq.push_back(mk(0,0,0,    0,0, 4,0, 0,3,'h33,  0,1, 0,0, 0,0));

    // Reset state, checked while rst_n is low.
    z = mk(0,0,0, 0,0, 0,0, 0,0,0, 0,1, 0,0, 0,0);
    #12;
    chk_all(-1, z);

    // First push accepted at the first rising edge after release.
    @(negedge clk);
    rst_n = 1'b1;
    foreach (vq[i]) begin
      drive(vq[i]);
      @(posedge clk);
      #1;
      chk_all(i, vq[i]);
      @(negedge clk);
    end

    // Asynchronous reset in the middle of a commit.
    drive(mk(1,5,'hAB, 0,0, 0,0, 0,0,0, 0,0, 0,0, 0,0));
    @(posedge clk); #1;
    chk("mid_cnt", 100, 32'(count), 32'd1);
    @(negedge clk);
    drive(mk(0,0,0, 0,0, 5,0, 0,0,0, 0,0, 0,0, 0,0));
    @(posedge clk); #1;
    chk("mid_wr_en", 101, 32'(wr_en), 32'd1);
    chk("mid_addr",  101, 32'(wr_addr), 32'd5);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all(102, z);

    // Release and push immediately.
    @(negedge clk);
    rst_n = 1'b1;
    drive(mk(1,9,'h5A, 0,0, 0,0, 0,0,0, 0,0, 0,0, 0,0));
    @(posedge clk); #1;
    chk("rel_cnt", 103, 32'(count), 32'd1);
    @(negedge clk);
    drive(mk(0,0,0, 0,0, 0,0, 0,0,0, 0,0, 0,0, 0,0));
    @(posedge clk); #1;
    chk("rel_wr_en",   104, 32'(wr_en),   32'd1);
    chk("rel_wr_addr", 104, 32'(wr_addr), 32'd9);
    chk("rel_wr_data", 104, wr_data,      32'h5A);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/reg_writeback.md
REG_WRITEBACK -- requirements
Module: reg_writeback

Interface
REQ-001 Parameter DATA_WIDTH, default 32: width of result data and register-file write data.
REQ-002 Parameter DEPTH, default 4: pending-result queue depth; power of two, >= 2.
REQ-003 Port clk  input  1: single clock; all state updates on its rising edge.
REQ-004 Port rst_n  input  1: reset, asynchronous and active-low.
REQ-005 Port in_valid  input  1: execute/load stage presents a result.
REQ-006 Port in_ready  output  1: queue can accept a result this cycle.
REQ-007 Port in_rd  input  5: destination register index.
REQ-008 Port in_data  input  DATA_WIDTH: result value.
REQ-009 Port flush  input  1: discard all queued, uncommitted results.
REQ-010 Port wb_stall  input  1: hold the queue head; no pop this cycle.
REQ-011 Port wr_en  output  1: register-file write enable.
REQ-012 Port wr_addr  output  5: register-file write index.
REQ-013 Port wr_data  output  DATA_WIDTH: register-file write data.
REQ-014 Port lk_addr1, lk_addr2  input  5 each: read-port addresses being decoded.
REQ-015 Port lk_hit1, lk_hit2  output  1 each: a pending write targets lk_addrN.
REQ-016 Port lk_data1, lk_data2  output  DATA_WIDTH each: forwarded value for a hit.
REQ-017 Port count  output  $clog2(DEPTH)+1: number of queued entries.

Function
REQ-018 The block SHALL be a FIFO of {rd, data} with a registered output stage (wr_en, wr_addr, wr_data).
REQ-019 in_ready SHALL be combinational: !full; a push occurs when in_valid && in_ready && !flush.
REQ-020 A full queue SHALL refuse a push even when a pop occurs in the same cycle.
REQ-021 A pop SHALL occur when the queue is non-empty && !wb_stall && !flush; the head loads the output stage.
REQ-022 On a pop with head rd != 0, the output stage SHALL set wr_en=1 for exactly one cycle; rd == 0 pops SHALL set wr_en=0.
REQ-023 Without a pop, wr_en SHALL be 0 on the next cycle; wr_addr and wr_data SHALL hold their values.
REQ-024 Latency: a push at edge k into an empty queue with no stall SHALL give wr_en=1 between edges k+1 and k+2, so the register file commits at k+2.
REQ-025 Throughput SHALL be one commit per cycle; results SHALL commit in push order.
REQ-026 A simultaneous push and pop on a non-full queue SHALL leave count unchanged.
REQ-027 Pointers SHALL wrap modulo DEPTH; count SHALL range 0..DEPTH.
REQ-028 flush SHALL zero count and both pointers at the next edge and block any push or pop that cycle; an output-stage write already asserted SHALL still complete.
REQ-029 The lookup SHALL search the output stage (when wr_en=1) plus all valid queue entries; the newest matching entry SHALL win; lk_addrN == 0 SHALL never hit.
REQ-030 When there is no hit, lk_dataN SHALL be 0.

Reset
REQ-031 While rst_n=0, the block SHALL immediately force count=0, pointers=0, wr_en=0, wr_addr=0 and wr_data=0, independent of clk.
REQ-032 in_ready SHALL read 1 during and immediately after reset.
REQ-033 After rst_n deasserts, the first push SHALL be accepted at the first rising edge.
REQ-034 Queue data storage SHALL NOT require reset.

Configuration
REQ-035 Macro WB_FORWARD_EN defined: lk_hitN and lk_dataN SHALL behave as in REQ-029 and REQ-030.
REQ-036 Macro WB_FORWARD_EN undefined: lk_hitN SHALL still flag pending writes, acting as a stall request, and lk_dataN SHALL be tied to 0 with no data mux logic.

Verification
REQ-037 Reset, then push rd=5 data=0xDEADBEEF at edge 1 -> wr_en=1, wr_addr=5, wr_data=0xDEADBEEF between edges 2 and 3; count returns to 0.
REQ-038 Set wb_stall=1 and push 4 results -> count=4, in_ready=0, and a 5th push is refused; release the stall -> 4 commits on consecutive cycles in push order.
REQ-039 Push rd=0 data=0x1 -> no wr_en pulse; lk_addr1=0 -> lk_hit1=0.
REQ-040 Queue holds rd=7 data=0x10 then rd=7 data=0x20; lk_addr2=7 -> lk_hit2=1 and lk_data2=0x20 (macro defined) or 0 (macro undefined).
REQ-041 Queue holds 3 entries and flush is asserted with in_valid=1 -> count=0 next cycle, nothing pushed, and no further wr_en pulses.
REQ-042 Assert rst_n=0 mid-commit, between clock edges -> wr_en drops to 0 immediately and count=0.
